// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared ALU: round-robin grant, one operation
// in flight, registered operand drive and a held response per requester.
module alu_arbiter (
  input  logic        Clk_in,
  input  logic        Reset_n_in,
  input  logic        Req0_Valid_in,
  input  logic [5:0]  Req0_Func_in,
  input  logic [31:0] Req0_A_in,
  input  logic [31:0] Req0_B_in,
  output logic        Req0_Ready_out,
  input  logic        Req1_Valid_in,
  input  logic [5:0]  Req1_Func_in,
  input  logic [31:0] Req1_A_in,
  input  logic [31:0] Req1_B_in,
  output logic        Req1_Ready_out,
  output logic        Rsp0_Valid_out,
  output logic [31:0] Rsp0_Data_out,
  output logic        Rsp0_Branch_out,
  output logic        Rsp0_Jump_out,
  input  logic        Rsp0_Ready_in,
  output logic        Rsp1_Valid_out,
  output logic [31:0] Rsp1_Data_out,
  output logic        Rsp1_Branch_out,
  output logic        Rsp1_Jump_out,
  input  logic        Rsp1_Ready_in,
  output logic [5:0]  Alu_Func_out,
  output logic [31:0] Alu_A_out,
  output logic [31:0] Alu_B_out,
  input  logic [31:0] Alu_O_in,
  input  logic        Alu_Branch_in,
  input  logic        Alu_Jump_in,
  output logic        Busy_out
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [5:0]  func;
    logic [31:0] a;
    logic [31:0] b;
  } req_t;

  state_t      state, state_nxt;
  logic        ptr, owner;
  logic [1:0]  grant;
  logic        rsp_take;
  req_t        win;
  logic [31:0] rsp_data;
  logic        rsp_br, rsp_jmp;

  // Grant is gated by reset so nothing looks accepted while reset is low.
  always_comb begin
    grant = '0;
    if (state == IDLE && Reset_n_in) begin
      grant[0] = Req0_Valid_in && (!ptr || !Req1_Valid_in);
      grant[1] = Req1_Valid_in && ( ptr || !Req0_Valid_in);
    end
  end

  assign win = grant[1] ? req_t'{Req1_Func_in, Req1_A_in, Req1_B_in}
                        : req_t'{Req0_Func_in, Req0_A_in, Req0_B_in};

  // Only the owner's consume strobe can retire the response.
  assign rsp_take = (state == RESP) && (owner ? Rsp1_Ready_in : Rsp0_Ready_in);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|grant) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_take) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk_in or negedge Reset_n_in) begin
    if (!Reset_n_in) begin
      state        <= IDLE;
      ptr          <= 1'b0;
      owner        <= 1'b0;
      Alu_Func_out <= '0;
      Alu_A_out    <= '0;
      Alu_B_out    <= '0;
      rsp_data     <= '0;
      rsp_br       <= 1'b0;
      rsp_jmp      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (|grant) begin
        owner        <= grant[1];
        Alu_Func_out <= win.func;
        Alu_A_out    <= win.a;
        Alu_B_out    <= win.b;
      end
      if (state == EXEC) begin
        rsp_data <= Alu_O_in;
        rsp_br   <= Alu_Branch_in;
        rsp_jmp  <= Alu_Jump_in;
      end
      if (rsp_take) ptr <= ~owner;
    end
  end

  assign Req0_Ready_out  = grant[0];
  assign Req1_Ready_out  = grant[1];
  assign Busy_out        = (state != IDLE);
  assign Rsp0_Valid_out  = (state == RESP) && !owner;
  assign Rsp1_Valid_out  = (state == RESP) &&  owner;
  assign Rsp0_Data_out   = rsp_data;
  assign Rsp0_Branch_out = rsp_br;
  assign Rsp0_Jump_out   = rsp_jmp;
  assign Rsp1_Data_out   = rsp_data;
  assign Rsp1_Branch_out = rsp_br;
  assign Rsp1_Jump_out   = rsp_jmp;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a stub ALU (O=A+B, Branch=A==B,
// Jump=Func==001000): vector table plus stall and mid-operation reset sequences.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v0 = 0, v1 = 0;
  logic [5:0]  f0 = '0, f1 = '0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        rd0, rd1;
  logic        rv0, rv1, rbr0, rbr1, rj0, rj1;
  logic [31:0] rdat0, rdat1;
  logic        rr0 = 1'b1, rr1 = 1'b1;
  logic [5:0]  alu_f;
  logic [31:0] alu_a, alu_b, alu_o;
  logic        alu_br, alu_j, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign alu_o  = alu_a + alu_b;
  assign alu_br = (alu_a == alu_b);
  assign alu_j  = (alu_f == 6'b001000);

  alu_arbiter dut (
    .Clk_in(clk), .Reset_n_in(rst_n),
    .Req0_Valid_in(v0), .Req0_Func_in(f0), .Req0_A_in(a0), .Req0_B_in(b0), .Req0_Ready_out(rd0),
    .Req1_Valid_in(v1), .Req1_Func_in(f1), .Req1_A_in(a1), .Req1_B_in(b1), .Req1_Ready_out(rd1),
    .Rsp0_Valid_out(rv0), .Rsp0_Data_out(rdat0), .Rsp0_Branch_out(rbr0), .Rsp0_Jump_out(rj0),
    .Rsp0_Ready_in(rr0),
    .Rsp1_Valid_out(rv1), .Rsp1_Data_out(rdat1), .Rsp1_Branch_out(rbr1), .Rsp1_Jump_out(rj1),
    .Rsp1_Ready_in(rr1),
    .Alu_Func_out(alu_f), .Alu_A_out(alu_a), .Alu_B_out(alu_b),
    .Alu_O_in(alu_o), .Alu_Branch_in(alu_br), .Alu_Jump_in(alu_j),
    .Busy_out(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Mutual exclusion of grants, sampled once per cycle well clear of both edges.
  always @(negedge clk) begin
    #2;
    if (rst_n) chk("ready_excl", {30'd0, rd1, rd0} == 32'd3, 32'd0);
  end

  typedef struct {
    logic        v0, v1;
    logic [5:0]  f0, f1;
    logic [31:0] a0, b0, a1, b1;
    logic        gnt;
    logic [31:0] data;
    logic        br, jmp;
  } vec_t;

  vec_t vecs[9];

  // Present one vector in IDLE, expect the named grant, then the response in RESP.
  task automatic run_vec(input vec_t v);
    int n;
    logic [31:0] rdat;
    logic rbr, rj;
    @(negedge clk);
    v0 = v.v0; v1 = v.v1; f0 = v.f0; f1 = v.f1;
    a0 = v.a0; b0 = v.b0; a1 = v.a1; b1 = v.b1;
    #1;
    n = 0;
    while (!(rd0 || rd1) && n < 10) begin
      @(negedge clk); #1; n++;
    end
    chk("grant", {30'd0, rd1, rd0}, v.gnt ? 32'd2 : 32'd1);
    @(negedge clk); #1;
    chk("exec_busy", {31'd0, busy}, 32'd1);
    chk("exec_rspv", {30'd0, rv1, rv0}, 32'd0);
    chk("exec_ready", {30'd0, rd1, rd0}, 32'd0);
    chk("alu_a", alu_a, v.gnt ? v.a1 : v.a0);
    chk("alu_b", alu_b, v.gnt ? v.b1 : v.b0);
    @(negedge clk); #1;
    rdat = v.gnt ? rdat1 : rdat0;
    rbr  = v.gnt ? rbr1 : rbr0;
    rj   = v.gnt ? rj1 : rj0;
    chk("resp_valid", {30'd0, rv1, rv0}, v.gnt ? 32'd2 : 32'd1);
    chk("resp_data", rdat, v.data);
    chk("resp_branch", {31'd0, rbr}, {31'd0, v.br});
    chk("resp_jump", {31'd0, rj}, {31'd0, v.jmp});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    //           v0 v1  f0         f1         a0  b0  a1            b1  gnt data   br jmp
    vecs[0] = '{1, 0, 6'b100000, 6'b000000, 5,  7,  0,            0,  0, 32'd12, 0, 0};
    vecs[1] = '{0, 1, 6'b000000, 6'b001000, 0,  0,  32'hFFFFFFFF, 1,  1, 32'd0,  0, 1};
    vecs[2] = '{1, 1, 6'b000000, 6'b000000, 1,  1,  2,            3,  0, 32'd2,  1, 0};
    vecs[3] = '{1, 1, 6'b000000, 6'b000000, 1,  1,  2,            3,  1, 32'd5,  0, 0};
    vecs[4] = '{1, 1, 6'b100000, 6'b001000, 10, 20, 7,            7,  0, 32'd30, 0, 0};
    vecs[5] = '{1, 1, 6'b100000, 6'b001000, 10, 20, 7,            7,  1, 32'd14, 1, 1};
    vecs[6] = '{1, 1, 6'b100000, 6'b001000, 10, 20, 7,            7,  0, 32'd30, 0, 0};
    vecs[7] = '{1, 1, 6'b100000, 6'b001000, 10, 20, 7,            7,  1, 32'd14, 1, 1};
    vecs[8] = '{1, 0, 6'b000000, 6'b000000, 100, 1, 0,            0,  0, 32'd101, 0, 0};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {30'd0, rd1, rd0}, 32'd0);
    chk("rst_rspv", {30'd0, rv1, rv0}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_f", {26'd0, alu_f}, 32'd0);
    chk("rst_data", rdat0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Owner holds off consume for 5 cycles; non-owner strobe must be ignored.
    @(negedge clk);
    rr0 = 1'b0; rr1 = 1'b1;
    v0 = 1; f0 = 6'b100000; a0 = 5; b0 = 7;
    v1 = 1; f1 = 6'b000000; a1 = 2; b1 = 3;
    #1;
    chk("stall_grant", {30'd0, rd1, rd0}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_valid", {30'd0, rv1, rv0}, 32'd1);
      chk("stall_data", rdat0, 32'd12);
      chk("stall_busy", {31'd0, busy}, 32'd1);
      chk("stall_rd1", {31'd0, rd1}, 32'd0);
      @(negedge clk);
    end
    rr0 = 1'b1; v0 = 0;
    @(negedge clk); #1;
    chk("after_consume_grant", {30'd0, rd1, rd0}, 32'd2);
    @(negedge clk);
    v1 = 0;
    @(negedge clk); #1;
    chk("after_consume_valid", {30'd0, rv1, rv0}, 32'd2);
    chk("after_consume_data", rdat1, 32'd5);

    run_vec(vecs[8]);

    // Reset while req1 is in EXEC: abandoned, pointer back to 0.
    @(negedge clk);
    v0 = 1; f0 = 6'b000000; a0 = 3; b0 = 4;
    v1 = 1; f1 = 6'b000000; a1 = 8; b1 = 8;
    #1;
    chk("prerst_grant", {30'd0, rd1, rd0}, 32'd2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ready", {30'd0, rd1, rd0}, 32'd0);
    chk("midrst_rspv", {30'd0, rv1, rv0}, 32'd0);
    chk("midrst_alu_a", alu_a, 32'd0);
    chk("midrst_data", rdat1, 32'd0);
    @(negedge clk);
    #1;
    chk("midrst_rspv_hold", {30'd0, rv1, rv0}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("postrst_grant", {30'd0, rd1, rd0}, 32'd1);
    @(negedge clk);
    v0 = 0; v1 = 0;
    #1;
    chk("postrst_exec_rspv", {30'd0, rv1, rv0}, 32'd0);
    @(negedge clk); #1;
    chk("postrst_valid", {30'd0, rv1, rv0}, 32'd1);
    chk("postrst_data", rdat0, 32'd7);
    @(negedge clk); #1;
    chk("postrst_idle", {31'd0, busy}, 32'd0);
    chk("postrst_alu_hold", alu_a, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
